brownout_dig_filter: RTL and testbench

- Digital back end of the brown-out detector, clocked from the rc oscillator output (osc_ck) in the dvdd domain.
- Consumes the raw comparator outputs dcomp (brown-out) and vunder (under-voltage).
- Produces the debounced brown-out output out_unbuf, which feeds the analog output buffer, plus synchronized status, a sticky event flag and a saturating event counter.
- Applies a post-enable settling blank, a symmetric debounce filter and a minimum assertion hold time.

---
 rtl/brownout_pkg.sv | 19 +
 rtl/brownout_sync.sv | 23 ++
 rtl/brownout_dig_filter.sv | 194 +++++++++++++++++++
 tb/tb_brownout_dig_filter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/brownout_pkg.sv
// Shared types and default constants for the brown-out digital filter.
package brownout_pkg;

  typedef enum logic [2:0] {
    ST_OFF          = 3'd0,
    ST_SETTLE       = 3'd1,
    ST_IDLE         = 3'd2,
    ST_ASSERT_PEND  = 3'd3,
    ST_BROWN        = 3'd4,
    ST_RELEASE_PEND = 3'd5
  } state_t;

  localparam int SYNC_STAGES_DEF   = 2;
  localparam int CNT_W_DEF         = 8;
  localparam int SETTLE_CYCLES_DEF = 16;

  localparam logic [7:0] BROUT_CNT_MAX = 8'd255;

endpackage

// File: rtl/brownout_sync.sv
// Multi-flop synchronizer for an asynchronous comparator output.
module brownout_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[STAGES-2:0], d};
    end
  end

  assign q = r_sh[STAGES-1];

endmodule

// File: rtl/brownout_dig_filter.sv
// Brown-out back end: synchronizes the comparators, blanks after enable,
// debounces dcomp symmetrically and enforces a minimum assertion time.
module brownout_dig_filter
  import brownout_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic             osc_ck,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             dcomp,
  input  logic             vunder,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [CNT_W-1:0] hold_len,
  input  logic             clr,
  output logic             out_unbuf,
  output logic             brout_filt,
  output logic             vunder_sync,
  output logic             brout_flag,
  output logic [7:0]       brout_cnt,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hold;
  logic             r_out;
  logic             r_flag;
  logic [7:0]       r_bcnt;

  state_t           w_nstate;
  logic [CNT_W-1:0] w_ncnt;
  logic [CNT_W-1:0] w_nhold;
  logic             w_nout;
  logic             w_rise;
  logic             w_dcomp_s;
  logic             w_vunder_s;
  logic             w_dsync_rst_n;
  logic [CNT_W-1:0] w_f;
  logic             w_f_one;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_cnt_hit;
  logic             w_hold_done;

  // The dcomp chain is held clear until settling completes, so stale samples
  // taken during the blank cannot count toward the first debounce.
  assign w_dsync_rst_n = rst_n && (r_state != ST_OFF) && (r_state != ST_SETTLE);

  brownout_sync #(.STAGES(SYNC_STAGES)) u_sync_dcomp (
    .clk   (osc_ck),
    .rst_n (w_dsync_rst_n),
    .d     (dcomp),
    .q     (w_dcomp_s)
  );

  brownout_sync #(.STAGES(SYNC_STAGES)) u_sync_vunder (
    .clk   (osc_ck),
    .rst_n (rst_n),
    .d     (vunder),
    .q     (w_vunder_s)
  );

  assign w_f         = (filt_len == '0) ? CNT_W'(1) : filt_len;
  assign w_f_one     = (w_f == CNT_W'(1));
  assign w_cnt_inc   = {1'b0, r_cnt} + (CNT_W + 1)'(1);
  assign w_cnt_hit   = (w_cnt_inc >= {1'b0, w_f});
  assign w_hold_done = (r_hold >= hold_len);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_nhold  = r_hold;
    if (!ena) begin
      w_nstate = ST_OFF;
      w_ncnt   = '0;
      w_nhold  = '0;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_nstate = ST_SETTLE;
          w_ncnt   = '0;
        end
        ST_SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            w_nstate = ST_IDLE;
            w_ncnt   = '0;
          end else begin
            w_ncnt = w_cnt_inc[CNT_W-1:0];
          end
        end
        ST_IDLE: begin
          if (w_dcomp_s) begin
            if (w_f_one) begin
              w_nstate = ST_BROWN;
              w_ncnt   = '0;
              w_nhold  = CNT_W'(1);
            end else begin
              w_nstate = ST_ASSERT_PEND;
              w_ncnt   = CNT_W'(1);
            end
          end
        end
        ST_ASSERT_PEND: begin
          if (!w_dcomp_s) begin
            w_nstate = ST_IDLE;
            w_ncnt   = '0;
          end else if (w_cnt_hit) begin
            w_nstate = ST_BROWN;
            w_ncnt   = '0;
            w_nhold  = CNT_W'(1);
          end else begin
            w_ncnt = w_cnt_inc[CNT_W-1:0];
          end
        end
        ST_BROWN: begin
          // r_hold counts completed high cycles; it stops once it reaches H.
          if (!w_hold_done) begin
            w_nhold = r_hold + CNT_W'(1);
          end
          if (w_hold_done && !w_dcomp_s) begin
            if (w_f_one) begin
              w_nstate = ST_IDLE;
              w_ncnt   = '0;
            end else begin
              w_nstate = ST_RELEASE_PEND;
              w_ncnt   = CNT_W'(1);
            end
          end
        end
        ST_RELEASE_PEND: begin
          if (w_dcomp_s) begin
            w_nstate = ST_BROWN;
            w_ncnt   = '0;
          end else if (w_cnt_hit) begin
            w_nstate = ST_IDLE;
            w_ncnt   = '0;
          end else begin
            w_ncnt = w_cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          w_nstate = ST_OFF;
          w_ncnt   = '0;
          w_nhold  = '0;
        end
      endcase
    end
  end

  assign w_nout = (w_nstate == ST_BROWN) || (w_nstate == ST_RELEASE_PEND);
  assign w_rise = w_nout && !r_out;

  always_ff @(posedge osc_ck) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      r_hold  <= w_nhold;
      r_out   <= w_nout;
    end
  end

  // Event bookkeeping survives ena=0; only reset or clr clears it.
  always_ff @(posedge osc_ck) begin
    if (!rst_n) begin
      r_flag <= 1'b0;
      r_bcnt <= '0;
    end else if (clr) begin
      r_flag <= 1'b0;
      r_bcnt <= '0;
    end else if (w_rise) begin
      r_flag <= 1'b1;
      if (r_bcnt != BROUT_CNT_MAX) begin
        r_bcnt <= r_bcnt + 8'd1;
      end
    end
  end

  assign out_unbuf   = r_out;
  assign brout_filt  = ena && w_dcomp_s;
  assign vunder_sync = ena && w_vunder_s;
  assign brout_flag  = r_flag;
  assign brout_cnt   = r_bcnt;
  assign state       = r_state;

endmodule

// File: tb/tb_brownout_dig_filter.sv
// Directed bench for brownout_dig_filter: per-cycle {out_unbuf,state} trace
// expectations are queued ahead of stimulus and popped after each edge.
module tb_brownout_dig_filter;
  import brownout_pkg::*;

  logic       osc_ck;
  logic       rst_n;
  logic       ena;
  logic       dcomp;
  logic       vunder;
  logic [7:0] filt_len;
  logic [7:0] hold_len;
  logic       clr;
  logic       out_unbuf;
  logic       brout_filt;
  logic       vunder_sync;
  logic       brout_flag;
  logic [7:0] brout_cnt;
  logic [2:0] state;

  int n_vec;
  int n_fail;
  logic [3:0] exp_q[$];

  brownout_dig_filter dut (
    .osc_ck      (osc_ck),
    .rst_n       (rst_n),
    .ena         (ena),
    .dcomp       (dcomp),
    .vunder      (vunder),
    .filt_len    (filt_len),
    .hold_len    (hold_len),
    .clr         (clr),
    .out_unbuf   (out_unbuf),
    .brout_filt  (brout_filt),
    .vunder_sync (vunder_sync),
    .brout_flag  (brout_flag),
    .brout_cnt   (brout_cnt),
    .state       (state)
  );

  // clock / reset
  initial osc_ck = 1'b0;
  always #5 osc_ck = ~osc_ck;

  task automatic step();
    @(posedge osc_ck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic o, input state_t s, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({o, s});
  endtask

  // drive dcomp for n cycles, comparing the trace against the queue each edge
  task automatic cyc(input string tag, input logic d, input int n);
    logic [3:0] e;
    for (int i = 0; i < n; i++) begin
      dcomp = d;
      step();
      if (exp_q.size() == 0) begin
        chk({tag, "_qempty"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(tag, {28'd0, out_unbuf, state}, {28'd0, e});
      end
    end
  endtask

  task automatic drive(input logic d, input int n);
    for (int i = 0; i < n; i++) begin
      dcomp = d;
      step();
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 2);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    dcomp    = 1'b1;
    vunder   = 1'b1;
    clr      = 1'b0;
    filt_len = 8'd2;
    hold_len = 8'd0;

    // reset: every output low
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", {17'd0, out_unbuf, brout_filt, vunder_sync, brout_flag, brout_cnt, state}, 32'd0);
    end

    // enable with dcomp high: 16 settle cycles, then rise SYNC_STAGES+F later
    rst_n = 1'b1;
    ena   = 1'b1;
    push(1'b0, ST_SETTLE, 16);
    push(1'b0, ST_IDLE, 3);
    push(1'b0, ST_ASSERT_PEND, 1);
    push(1'b1, ST_BROWN, 1);
    cyc("settle_rise", 1'b1, 21);
    chk("settle_flag", {31'd0, brout_flag}, 32'd1);
    chk("settle_cnt", {24'd0, brout_cnt}, 32'd1);
    chk("brout_filt_hi", {31'd0, brout_filt}, 32'd1);
    chk("vunder_sync_hi", {31'd0, vunder_sync}, 32'd1);

    clr = 1'b1;
    push(1'b1, ST_BROWN, 1);
    cyc("clr_cycle", 1'b1, 1);
    clr = 1'b0;
    chk("clr_flag", {31'd0, brout_flag}, 32'd0);
    chk("clr_cnt", {24'd0, brout_cnt}, 32'd0);

    // debounce with F=4: release, reject 3-cycle pulse, accept 6-cycle pulse
    filt_len = 8'd4;
    push(1'b1, ST_BROWN, 2);
    push(1'b1, ST_RELEASE_PEND, 3);
    push(1'b0, ST_IDLE, 3);
    cyc("f4_release", 1'b0, 8);
    push(1'b0, ST_IDLE, 2);
    push(1'b0, ST_ASSERT_PEND, 3);
    push(1'b0, ST_IDLE, 3);
    cyc("reject3_hi", 1'b1, 3);
    cyc("reject3_lo", 1'b0, 5);
    chk("reject3_cnt", {24'd0, brout_cnt}, 32'd0);
    chk("reject3_flag", {31'd0, brout_flag}, 32'd0);
    push(1'b0, ST_IDLE, 2);
    push(1'b0, ST_ASSERT_PEND, 3);
    push(1'b1, ST_BROWN, 3);
    push(1'b1, ST_RELEASE_PEND, 3);
    push(1'b0, ST_IDLE, 3);
    cyc("accept6_hi", 1'b1, 6);
    cyc("accept6_lo", 1'b0, 8);
    chk("accept6_flag", {31'd0, brout_flag}, 32'd1);
    chk("accept6_cnt", {24'd0, brout_cnt}, 32'd1);

    // hold: F=2, H=10, dcomp high for 4 cycles
    filt_len = 8'd2;
    hold_len = 8'd10;
    push(1'b0, ST_IDLE, 2);
    push(1'b0, ST_ASSERT_PEND, 1);
    push(1'b1, ST_BROWN, 10);
    push(1'b1, ST_RELEASE_PEND, 1);
    push(1'b0, ST_IDLE, 2);
    cyc("hold_hi", 1'b1, 4);
    cyc("hold_lo", 1'b0, 12);
    chk("hold_cnt", {24'd0, brout_cnt}, 32'd2);

    // release glitch: F=5, 3-cycle dropout returns to BROWN
    filt_len = 8'd5;
    hold_len = 8'd0;
    push(1'b0, ST_IDLE, 2);
    push(1'b0, ST_ASSERT_PEND, 4);
    push(1'b1, ST_BROWN, 3);
    push(1'b1, ST_RELEASE_PEND, 3);
    push(1'b1, ST_BROWN, 2);
    cyc("glitch_hi", 1'b1, 7);
    cyc("glitch_lo", 1'b0, 3);
    cyc("glitch_back", 1'b1, 4);
    chk("glitch_cnt", {24'd0, brout_cnt}, 32'd3);

    // disable mid brown-out, then re-enable into a fresh settle
    ena = 1'b0;
    push(1'b0, ST_OFF, 1);
    cyc("disable", 1'b0, 1);
    chk("disable_cnt", {24'd0, brout_cnt}, 32'd3);
    chk("disable_flag", {31'd0, brout_flag}, 32'd1);
    chk("disable_vsync", {31'd0, vunder_sync}, 32'd0);
    chk("disable_filt", {31'd0, brout_filt}, 32'd0);
    ena = 1'b1;
    push(1'b0, ST_SETTLE, 16);
    push(1'b0, ST_IDLE, 1);
    cyc("reenable", 1'b0, 17);

    // saturation with F=1, H=0
    filt_len = 8'd0;
    pulses(200);
    chk("sat_mid_cnt", {24'd0, brout_cnt}, 32'd203);
    pulses(60);
    chk("sat_cnt", {24'd0, brout_cnt}, 32'd255);
    chk("sat_flag", {31'd0, brout_flag}, 32'd1);

    // clr coincides with a rising event: clear wins
    drive(1'b1, 1);
    drive(1'b0, 1);
    clr = 1'b1;
    drive(1'b0, 1);
    clr = 1'b0;
    chk("clr_rise_out", {31'd0, out_unbuf}, 32'd1);
    chk("clr_rise_cnt", {24'd0, brout_cnt}, 32'd0);
    chk("clr_rise_flag", {31'd0, brout_flag}, 32'd0);
    pulses(1);
    chk("post_clr_cnt", {24'd0, brout_cnt}, 32'd1);
    chk("post_clr_flag", {31'd0, brout_flag}, 32'd1);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
